// File: rtl/rx_controller.sv
// rx_controller: UART receive-path controller.
// Validates each completed frame against the frame configuration sampled with
// frame_valid_i, extracts the data field, and queues {fe, pe, data} into a
// receive buffer drained by the register interface. It also reports buffer
// status and a sticky overrun flag.
// Build option: define WBUART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer.
// Without it, the buffer is a single holding register.
module rx_controller #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cr_rxen_i,
    input  logic               cr_ds_i,
    input  logic [1:0]         cr_p_i,
    input  logic               cr_s_i,
    input  logic [10:0]        frame_i,
    input  logic               parity_err_i,
    input  logic               frame_valid_i,
    input  logic               rd_i,
    input  logic               flush_i,
    input  logic               ore_clr_i,
    output logic [7:0]         rdata_o,
    output logic               rx_pe_o,
    output logic               rx_fe_o,
    output logic               rxne_o,
    output logic               rx_full_o,
    output logic [LEVEL_W-1:0] rx_level_o,
    output logic               ore_o
);

    // Capture-stage signals
    logic       par_en;
    logic [3:0] sidx;
    logic [3:0] sidx_n;
    logic [7:0] cap_data;
    logic       cap_fe;
    logic       cap_pe;
    logic       capture;

    // Pending entry: one cycle between capture and write
    logic       pend;
    logic [7:0] pend_data;
    logic       pend_fe;
    logic       pend_pe;
    logic [9:0] entry;

    // Buffer control
    logic [LEVEL_W-1:0] level;
    logic               rxne;
    logic               full;
    logic               pop;
    logic               wr_ok;
    logic               ovr;
    logic [9:0]         head;
    logic               ore;

`ifdef WBUART_RX_FIFO_EN
    localparam int unsigned DEPTH = FIFO_DEPTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Read/write pointers; power-of-two depth lets them wrap naturally
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + PTR_W'(1);
            if (pop)   rptr <= rptr + PTR_W'(1);
        end
    end

    // Entry storage; contents are qualified by level, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wptr] <= entry;
    end

    assign head = mem[rptr];
`else
    localparam int unsigned DEPTH = 1;

    logic [9:0] hold;

    // Single holding register; validity is tracked by level
    always_ff @(posedge clk_i) begin
        if (wr_ok) hold <= entry;
    end

    assign head = hold;
`endif

    // Frame validation against the configuration present with frame_valid_i
    always_comb begin
        par_en   = (cr_p_i != 2'b00);
        sidx     = 4'd7 + {3'b000, cr_ds_i} + {3'b000, par_en};
        sidx_n   = sidx + 4'd1;
        cap_data = cr_ds_i ? frame_i[7:0] : {1'b0, frame_i[6:0]};
        cap_fe   = ~frame_i[sidx] | (cr_s_i & ~frame_i[sidx_n]);
        cap_pe   = parity_err_i & par_en;
        capture  = frame_valid_i & cr_rxen_i;
    end

    // Capture register; no stall, so consecutive pulses each produce an entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend      <= 1'b0;
            pend_data <= '0;
            pend_fe   <= 1'b0;
            pend_pe   <= 1'b0;
        end else begin
            pend <= capture & ~flush_i;
            if (capture) begin
                pend_data <= cap_data;
                pend_fe   <= cap_fe;
                pend_pe   <= cap_pe;
            end
        end
    end

    // When full, a same-cycle pop frees the slot, so the write is still accepted
    always_comb begin
        entry = {pend_fe, pend_pe, pend_data};
        rxne  = (level != '0);
        full  = (level == LEVEL_W'(DEPTH));
        pop   = rd_i & rxne & ~flush_i;
        wr_ok = pend & ~flush_i & (~full | pop);
        ovr   = pend & ~flush_i & full & ~pop;
    end

    // Occupancy count; the write and pop guards keep it within 0..DEPTH
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level <= '0;
        end else if (flush_i) begin
            level <= '0;
        end else if (wr_ok && !pop) begin
            level <= level + LEVEL_W'(1);
        end else if (pop && !wr_ok) begin
            level <= level - LEVEL_W'(1);
        end
    end

    // Sticky overrun; a new overrun wins over a same-cycle clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ore <= 1'b0;
        end else if (ovr) begin
            ore <= 1'b1;
        end else if (ore_clr_i) begin
            ore <= 1'b0;
        end
    end

    assign rdata_o    = rxne ? head[7:0] : '0;
    assign rx_pe_o    = rxne & head[8];
    assign rx_fe_o    = rxne & head[9];
    assign rxne_o     = rxne;
    assign rx_full_o  = full;
    assign rx_level_o = level;
    assign ore_o      = ore;

endmodule

// File: tb/tb_rx_controller.sv
// tb_rx_controller: randomized and directed checks of rx_controller against a
// queue-based reference model of the receive buffer.
module tb_rx_controller;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH + 1);
`ifdef WBUART_RX_FIFO_EN
    localparam int unsigned DEPTH = FIFO_DEPTH;
`else
    localparam int unsigned DEPTH = 1;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               rxen = 1'b1;
    logic               ds = 1'b1;
    logic [1:0]         p = 2'b00;
    logic               s = 1'b0;
    logic [10:0]        frame = '0;
    logic               parity_err = 1'b0;
    logic               frame_valid = 1'b0;
    logic               rd = 1'b0;
    logic               flush = 1'b0;
    logic               ore_clr = 1'b0;
    logic [7:0]         rdata;
    logic               rx_pe;
    logic               rx_fe;
    logic               rxne;
    logic               rx_full;
    logic [LEVEL_W-1:0] rx_level;
    logic               ore;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [9:0] q[$];
    logic       m_pend = 1'b0;
    logic [9:0] m_pend_entry = '0;
    logic       m_ore = 1'b0;

    rx_controller #(.FIFO_DEPTH(FIFO_DEPTH), .LEVEL_W(LEVEL_W)) dut (
        .clk_i(clk), .rst_i(rst), .cr_rxen_i(rxen), .cr_ds_i(ds), .cr_p_i(p),
        .cr_s_i(s), .frame_i(frame), .parity_err_i(parity_err),
        .frame_valid_i(frame_valid), .rd_i(rd), .flush_i(flush),
        .ore_clr_i(ore_clr), .rdata_o(rdata), .rx_pe_o(rx_pe), .rx_fe_o(rx_fe),
        .rxne_o(rxne), .rx_full_o(rx_full), .rx_level_o(rx_level), .ore_o(ore)
    );

    always #5 clk = ~clk;

    // Expected {fe, pe, data} for a frame: data bits, optional parity, then stop bits
    function automatic logic [9:0] model_entry(input logic [10:0] f, input logic perr,
                                               input logic cds, input logic [1:0] cp,
                                               input logic cs);
        int unsigned nbits;
        int unsigned stop;
        logic [7:0]  d;
        logic        fe;
        logic        pe;
        nbits = cds ? 8 : 7;
        stop  = nbits + ((cp != 2'b00) ? 1 : 0);
        d     = 8'((int'(f) % (1 << nbits)));
        fe    = (f[stop] == 1'b0) || (cs && f[stop + 1] == 1'b0);
        pe    = perr && (cp != 2'b00);
        return {fe, pe, d};
    endfunction

    // Advance the model by one clock using the inputs held across the edge
    task automatic model_step();
        logic popm;
        logic ovr;
        popm = rd && (q.size() != 0) && !flush;
        ovr  = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (popm) void'(q.pop_front());
            if (m_pend) begin
                if (q.size() < DEPTH) q.push_back(m_pend_entry);
                else ovr = 1'b1;
            end
        end
        if (ovr) m_ore = 1'b1;
        else if (ore_clr) m_ore = 1'b0;
        m_pend = frame_valid && rxen && !flush;
        if (m_pend) m_pend_entry = model_entry(frame, parity_err, ds, p, s);
    endtask

    // One clock of stimulus; returns at the following falling edge
    task automatic cycle(input logic fv, input logic [10:0] f, input logic perr,
                         input logic r, input logic fl, input logic clr);
        frame_valid = fv;
        frame       = f;
        parity_err  = perr;
        rd          = r;
        flush       = fl;
        ore_clr     = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        frame_valid = 1'b0;
        parity_err  = 1'b0;
        rd          = 1'b0;
        flush       = 1'b0;
        ore_clr     = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push8(input logic [7:0] d);
        ds = 1'b1; p = 2'b00; s = 1'b0;
        cycle(1'b1, {3'b001, d}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        q.delete(); m_pend = 1'b0; m_ore = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if ({rx_pe, rx_fe, rxne, rx_full, ore} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {rx_pe, rx_fe, rxne, rx_full, ore}); end
        checks++; if (rx_level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", rx_level); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_8n1();
        ds = 1'b1; p = 2'b00; s = 1'b0;
        cycle(1'b1, 11'h1A5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (rxne !== 1'b0) begin failures++; $display("FAIL 8n1_latency_rxne got=%b exp=0", rxne); end
        idle();
        checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL 8n1_rdata got=%h exp=a5", rdata); end
        checks++; if ({rx_fe, rx_pe} !== 2'b00) begin failures++; $display("FAIL 8n1_err got=%b exp=00", {rx_fe, rx_pe}); end
        checks++; if (rxne !== 1'b1 || rx_level !== LEVEL_W'(1)) begin failures++; $display("FAIL 8n1_status got=%b/%0d exp=1/1", rxne, rx_level); end
        pop();
        checks++; if (rxne !== 1'b0 || rdata !== 8'h00) begin failures++; $display("FAIL 8n1_pop got=%b/%h exp=0/00", rxne, rdata); end
    endtask

    task automatic test_7e2();
        ds = 1'b0; p = 2'b10; s = 1'b1;
        cycle(1'b1, 11'h27F, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        checks++; if (rdata !== 8'h7F || rx_fe !== 1'b1 || rx_pe !== 1'b0) begin failures++; $display("FAIL 7e2_fe got=%h/%b/%b exp=7f/1/0", rdata, rx_fe, rx_pe); end
        pop();
        cycle(1'b1, 11'h37F, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        checks++; if (rdata !== 8'h7F || rx_fe !== 1'b0 || rx_pe !== 1'b1) begin failures++; $display("FAIL 7e2_pe got=%h/%b/%b exp=7f/0/1", rdata, rx_fe, rx_pe); end
        pop();
    endtask

    task automatic test_overrun();
        for (int unsigned i = 0; i <= DEPTH; i++) push8(8'(i));
        idle();
        checks++; if (rx_full !== 1'b1 || ore !== 1'b1) begin failures++; $display("FAIL ovr_flags got=%b/%b exp=1/1", rx_full, ore); end
        checks++; if (rx_level !== LEVEL_W'(DEPTH)) begin failures++; $display("FAIL ovr_level got=%0d exp=%0d", rx_level, DEPTH); end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            checks++; if (rdata !== 8'(i)) begin failures++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, rdata, 8'(i)); end
            pop();
        end
        checks++; if (rxne !== 1'b0 || ore !== 1'b1) begin failures++; $display("FAIL ovr_drained got=%b/%b exp=0/1", rxne, ore); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (ore !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", ore); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[$];
        logic [7:0] nv;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            vals.push_back(8'($urandom_range(0, 255)));
            push8(vals[i]);
        end
        idle();
        checks++; if (rx_level !== LEVEL_W'(DEPTH) || rx_full !== 1'b1) begin failures++; $display("FAIL b2b_fill got=%0d/%b exp=%0d/1", rx_level, rx_full, DEPTH); end
        nv = 8'($urandom_range(0, 255));
        push8(nv);
        vals.push_back(nv);
        pop();
        void'(vals.pop_front());
        checks++; if (ore !== 1'b0 || rx_level !== LEVEL_W'(DEPTH)) begin failures++; $display("FAIL b2b_share got=%b/%0d exp=0/%0d", ore, rx_level, DEPTH); end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            checks++; if (rdata !== vals[i]) begin failures++; $display("FAIL b2b_pop%0d got=%h exp=%h", i, rdata, vals[i]); end
            if (i == DEPTH - 1) begin
                checks++; if (rdata !== nv) begin failures++; $display("FAIL b2b_last got=%h exp=%h", rdata, nv); end
            end
            pop();
        end
    endtask

    task automatic test_wrap();
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned k = 0; k < DEPTH; k++) push8(8'(r * DEPTH + k));
            idle();
            for (int unsigned k = 0; k < DEPTH; k++) begin
                checks++; if (rdata !== 8'(r * DEPTH + k)) begin failures++; $display("FAIL wrap_%0d got=%h exp=%h", r * DEPTH + k, rdata, 8'(r * DEPTH + k)); end
                pop();
            end
        end
    endtask

    task automatic test_async_reset();
        push8(8'h11); push8(8'h22); push8(8'h33);
        #2 rst = 1'b1;
        q.delete(); m_pend = 1'b0; m_ore = 1'b0;
        #1;
        checks++; if ({rdata, rx_pe, rx_fe, rxne, rx_full, ore} !== 13'b0 || rx_level !== '0) begin failures++; $display("FAIL areset_outputs got=%h/%b%b%b%b%b/%0d exp=0", rdata, rx_pe, rx_fe, rxne, rx_full, ore, rx_level); end
        #1 rst = 1'b0;
        @(negedge clk);
        idle();
        checks++; if (rx_level !== '0 || rxne !== 1'b0) begin failures++; $display("FAIL areset_pending got=%0d/%b exp=0/0", rx_level, rxne); end
    endtask

    task automatic test_flush();
        for (int unsigned i = 0; i <= DEPTH; i++) push8(8'(i + 8'h40));
        idle();
        push8(8'h5A);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (rx_level !== '0 || rxne !== 1'b0 || rx_full !== 1'b0) begin failures++; $display("FAIL flush_level got=%0d/%b/%b exp=0/0/0", rx_level, rxne, rx_full); end
        checks++; if (ore !== 1'b1) begin failures++; $display("FAIL flush_ore got=%b exp=1", ore); end
        idle();
        checks++; if (rx_level !== '0) begin failures++; $display("FAIL flush_pending got=%0d exp=0", rx_level); end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_rxen_off();
        rxen = 1'b0;
        for (int i = 0; i < 3; i++) push8(8'($urandom_range(0, 255)));
        idle();
        checks++; if (rx_level !== '0 || ore !== 1'b0) begin failures++; $display("FAIL rxen_off got=%0d/%b exp=0/0", rx_level, ore); end
        rxen = 1'b1;
    endtask

    task automatic test_random();
        logic [9:0] h;
        for (int n = 0; n < 600; n++) begin
            rxen = ($urandom_range(0, 9) != 0);
            ds   = 1'($urandom_range(0, 1));
            p    = 2'($urandom_range(0, 3));
            s    = 1'($urandom_range(0, 1));
            cycle(($urandom_range(0, 9) < 4), 11'($urandom_range(0, 2047)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 19) < 7),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0));
            h = (q.size() != 0) ? q[0] : 10'h000;
            checks++; if (rx_level !== LEVEL_W'(q.size()) || rxne !== (q.size() != 0) || rx_full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rnd_status n=%0d got=%0d/%b/%b exp=%0d", n, rx_level, rxne, rx_full, q.size()); end
            checks++; if (ore !== m_ore) begin failures++; $display("FAIL rnd_ore n=%0d got=%b exp=%b", n, ore, m_ore); end
            checks++; if (rdata !== h[7:0]) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rdata, h[7:0]); end
            if (q.size() != 0) begin
                checks++; if ({rx_fe, rx_pe} !== h[9:8]) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, {rx_fe, rx_pe}, h[9:8]); end
            end
        end
        rxen = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_7e2();
        test_overrun();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_flush();
        test_rxen_off();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
